// File: rtl/riscv_csr_file.sv
// -----------------------------------------------------------------------------
// riscv_csr_file
//   Machine-mode CSR storage beside the register file. One combinational read
//   port (with same-cycle bypass of the pending EX-stage write) and one write
//   port that commits at the clock edge. Also holds the 64-bit mcycle and
//   minstret counters.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active high
//   rd_addr_i      CSR read address
//   rval_o         CSR read data (combinational)
//   rd_illegal_o   read address unmapped (combinational)
//   ex_csr_reg_i   CSR write address
//   ex_csr_wval_i  CSR write value
//   ex_csr_we_i    CSR write enable
//   wr_illegal_o   registered: previous-cycle write hit a read-only/unmapped CSR
//   retire_i       one instruction retired this cycle
// -----------------------------------------------------------------------------
module riscv_csr_file #(
  parameter int unsigned MXLEN   = 32,
  parameter bit          HAS_RVC = 1'b0,
  parameter int unsigned HARTID  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [11:0]      rd_addr_i,
  output logic [MXLEN-1:0] rval_o,
  output logic             rd_illegal_o,
  input  logic [11:0]      ex_csr_reg_i,
  input  logic [MXLEN-1:0] ex_csr_wval_i,
  input  logic             ex_csr_we_i,
  output logic             wr_illegal_o,
  input  logic             retire_i
);

  localparam int unsigned CNT_W   = 64;
  localparam bit          IS_RV32 = (MXLEN == 32);

  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Compressed ISA allows 2-byte aligned return addresses, otherwise 4-byte.
  localparam logic [MXLEN-1:0] EPC_MASK = HAS_RVC ? ~MXLEN'(1) : ~MXLEN'(3);

  logic [MXLEN-1:0] mscratch_q, mscratch_d;
  logic [MXLEN-1:0] mepc_q,     mepc_d;
  logic [MXLEN-1:0] mcause_q,   mcause_d;
  logic [MXLEN-1:0] mtval_q,    mtval_d;
  logic [CNT_W-1:0] mcycle_q,   mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic             wr_illegal_q, wr_illegal_d;

  logic             wr_ok;
  logic             wr_en;
  logic [MXLEN-1:0] wval_eff;
  logic [MXLEN-1:0] rd_data;
  logic             rd_hit;
  logic             rd_bypass;

  // Write target decode: writable machine CSRs only (addr[11:10]==2'b11 is RO).
  always_comb begin
    wr_ok = 1'b0;
    case (ex_csr_reg_i)
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MINSTRET:     wr_ok = 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH:   wr_ok = IS_RV32;
      default:                      wr_ok = 1'b0;
    endcase
  end

  assign wr_en    = ex_csr_we_i & wr_ok;
  assign wval_eff = (ex_csr_reg_i == CSR_MEPC) ? (ex_csr_wval_i & EPC_MASK) : ex_csr_wval_i;

  // Read mux of committed state.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (rd_addr_i)
      CSR_MSCRATCH:              rd_data = mscratch_q;
      CSR_MEPC:                  rd_data = mepc_q;
      CSR_MCAUSE:                rd_data = mcause_q;
      CSR_MTVAL:                 rd_data = mtval_q;
      CSR_MHARTID:               rd_data = MXLEN'(HARTID);
      CSR_MCYCLE, CSR_CYCLE:     rd_data = MXLEN'(mcycle_q);
      CSR_MINSTRET, CSR_INSTRET: rd_data = MXLEN'(minstret_q);
      CSR_MCYCLEH, CSR_CYCLEH: begin
        if (IS_RV32) rd_data = MXLEN'(mcycle_q[63:32]);
        else         rd_hit  = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (IS_RV32) rd_data = MXLEN'(minstret_q[63:32]);
        else         rd_hit  = 1'b0;
      end
      default:                   rd_hit  = 1'b0;
    endcase
  end

  // A pending write to the same writable CSR is forwarded. Counter halves need
  // no merge here: the addressed half of the merged value is the write value.
  assign rd_bypass    = wr_en && (ex_csr_reg_i == rd_addr_i);
  assign rval_o       = rd_bypass ? wval_eff : rd_data;
  assign rd_illegal_o = ~rd_hit;
  assign wr_illegal_o = wr_illegal_q;

  // Next-state: counters free-run; a software write to a counter half replaces
  // that half and freezes the other one for the cycle.
  always_comb begin
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mcycle_d     = mcycle_q + 64'd1;
    minstret_d   = minstret_q + 64'(retire_i);
    wr_illegal_d = ex_csr_we_i & ~wr_ok;
    if (wr_en) begin
      case (ex_csr_reg_i)
        CSR_MSCRATCH:  mscratch_d = wval_eff;
        CSR_MEPC:      mepc_d     = wval_eff;
        CSR_MCAUSE:    mcause_d   = wval_eff;
        CSR_MTVAL:     mtval_d    = wval_eff;
        CSR_MCYCLE:    mcycle_d   = IS_RV32 ? {mcycle_q[63:32], ex_csr_wval_i[31:0]}
                                            : 64'(ex_csr_wval_i);
        CSR_MINSTRET:  minstret_d = IS_RV32 ? {minstret_q[63:32], ex_csr_wval_i[31:0]}
                                            : 64'(ex_csr_wval_i);
        CSR_MCYCLEH:   mcycle_d   = {ex_csr_wval_i[31:0], mcycle_q[31:0]};
        CSR_MINSTRETH: minstret_d = {ex_csr_wval_i[31:0], minstret_q[31:0]};
        default:       ;
      endcase
    end
  end

  // State register; reset dominates writes and increments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      wr_illegal_q <= 1'b0;
    end else begin
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
      wr_illegal_q <= wr_illegal_d;
    end
  end

endmodule

// File: tb/tb_riscv_csr_file.sv
// -----------------------------------------------------------------------------
// tb_riscv_csr_file
//   Directed bench: a table of single-cycle read/write vectors plus hand-written
//   sequences for counters, wrap, write-vs-increment priority and reset.
//   Three instances share stimulus: RV32 (HAS_RVC=0), RV32 (HAS_RVC=1) and
//   RV64 (HARTID=5).
// -----------------------------------------------------------------------------
module tb_riscv_csr_file;

  logic        clk;
  logic        rst;
  logic [11:0] rd_addr;
  logic [11:0] waddr;
  logic [31:0] wval;
  logic [63:0] wval64;
  logic        we;
  logic        retire;

  logic [31:0] rval32, rval_rvc;
  logic [63:0] rval64;
  logic        rd_ill32, rd_ill_rvc, rd_ill64;
  logic        wr_ill32, wr_ill_rvc, wr_ill64;

  int n_chk;
  int n_fail;
  longint unsigned exp_cyc;
  longint unsigned exp_ins;
  longint unsigned nxt;

  riscv_csr_file #(.MXLEN(32), .HAS_RVC(1'b0), .HARTID(0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rval_o(rval32),
    .rd_illegal_o(rd_ill32), .ex_csr_reg_i(waddr), .ex_csr_wval_i(wval),
    .ex_csr_we_i(we), .wr_illegal_o(wr_ill32), .retire_i(retire)
  );

  riscv_csr_file #(.MXLEN(32), .HAS_RVC(1'b1), .HARTID(0)) u_dut_rvc (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rval_o(rval_rvc),
    .rd_illegal_o(rd_ill_rvc), .ex_csr_reg_i(waddr), .ex_csr_wval_i(wval),
    .ex_csr_we_i(we), .wr_illegal_o(wr_ill_rvc), .retire_i(retire)
  );

  riscv_csr_file #(.MXLEN(64), .HAS_RVC(1'b0), .HARTID(5)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rval_o(rval64),
    .rd_illegal_o(rd_ill64), .ex_csr_reg_i(waddr), .ex_csr_wval_i(wval64),
    .ex_csr_we_i(we), .wr_illegal_o(wr_ill64), .retire_i(retire)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] rd;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wv;
    logic [31:0] exp_rval;
    logic        exp_rd_ill;
    logic        exp_wr_ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs sampled at the edge, outputs inspected 1 unit later.
  task automatic step();
    @(posedge clk);
    exp_cyc = exp_cyc + 1;
    if (retire) exp_ins = exp_ins + 1;
    #1;
  endtask

  task automatic rd32(input string name, input logic [11:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(name, {32'h0, rval32}, {32'h0, exp});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    we     = 1'b1;
    waddr  = a;
    wval   = v;
    wval64 = {32'h0, v};
  endtask

  initial begin
    vec[0]  = '{12'h340, 1'b0, 12'h000, 32'h0,        32'h0,        1'b0, 1'b0};
    vec[1]  = '{12'h340, 1'b1, 12'h340, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vec[2]  = '{12'h340, 1'b0, 12'h000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vec[3]  = '{12'h341, 1'b1, 12'h341, 32'h00001003, 32'h00001000, 1'b0, 1'b0};
    vec[4]  = '{12'h341, 1'b0, 12'h000, 32'h0,        32'h00001000, 1'b0, 1'b0};
    vec[5]  = '{12'h340, 1'b1, 12'h342, 32'h8000000B, 32'hDEADBEEF, 1'b0, 1'b0};
    vec[6]  = '{12'h342, 1'b0, 12'h000, 32'h0,        32'h8000000B, 1'b0, 1'b0};
    vec[7]  = '{12'h343, 1'b1, 12'h343, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vec[8]  = '{12'h7FF, 1'b1, 12'h7FF, 32'h00000001, 32'h0,        1'b1, 1'b1};
    vec[9]  = '{12'hF14, 1'b1, 12'hF14, 32'h00000009, 32'h0,        1'b0, 1'b1};
    vec[10] = '{12'h343, 1'b0, 12'h000, 32'h0,        32'h12345678, 1'b0, 1'b0};
    vec[11] = '{12'h3A0, 1'b1, 12'h3A0, 32'h00000055, 32'h0,        1'b1, 1'b1};
    vec[12] = '{12'h000, 1'b0, 12'h000, 32'h0,        32'h0,        1'b1, 1'b0};

    n_chk = 0; n_fail = 0;
    clk = 1'b0; rst = 1'b1; we = 1'b0; retire = 1'b0;
    waddr = '0; wval = '0; wval64 = '0; rd_addr = 12'h340;

    // Reset state
    @(posedge clk); #1;
    exp_cyc = 0; exp_ins = 0;
    rd32("rst_mscratch", 12'h340, 32'h0);
    rd32("rst_mcycle", 12'hB00, 32'h0);
    rd32("rst_minstret", 12'hB02, 32'h0);
    chk("rst_wr_ill", {63'h0, wr_ill32}, 64'h0);
    rst = 1'b0;

    // Ten idle cycles -> cycle counter reads 10 through both aliases
    for (int i = 0; i < 10; i++) step();
    rd32("idle_mcycle", 12'hB00, 32'd10);
    rd32("idle_cycle", 12'hC00, 32'd10);

    // Table-driven register accesses
    for (int i = 0; i < NV; i++) begin
      rd_addr = vec[i].rd;
      we      = vec[i].we;
      waddr   = vec[i].wa;
      wval    = vec[i].wv;
      wval64  = {32'h0, vec[i].wv};
      #1;
      chk($sformatf("vec%0d_rval", i), {32'h0, rval32}, {32'h0, vec[i].exp_rval});
      chk($sformatf("vec%0d_rd_ill", i), {63'h0, rd_ill32}, {63'h0, vec[i].exp_rd_ill});
      step();
      we = 1'b0;
      chk($sformatf("vec%0d_wr_ill", i), {63'h0, wr_ill32}, {63'h0, vec[i].exp_wr_ill});
    end

    // mepc alignment with compressed support, and RV64 map differences
    rd_addr = 12'h341; #1;
    chk("rvc_mepc", {32'h0, rval_rvc}, 64'h1002);
    rd_addr = 12'hF14; #1;
    chk("rv64_hartid", rval64, 64'd5);
    rd_addr = 12'hB80; #1;
    chk("rv64_b80_ill", {63'h0, rd_ill64}, 64'h1);
    chk("rv64_b80_rval", rval64, 64'h0);
    chk("rv32_b80_mapped", {63'h0, rd_ill32}, 64'h0);
    step();

    // Write to read-only counter alias: flagged, counter untouched
    wr(12'hC00, 32'h5);
    rd_addr = 12'hC00; #1;
    chk("ro_no_bypass", {32'h0, rval32}, {32'h0, exp_cyc[31:0]});
    step();
    we = 1'b0;
    chk("ro_wr_ill", {63'h0, wr_ill32}, 64'h1);
    rd32("ro_cycle_kept", 12'hC00, exp_cyc[31:0]);
    step();
    chk("ro_wr_ill_pulse", {63'h0, wr_ill32}, 64'h0);

    // Low-half write, high-half write, then carry on wrap of the low half
    wr(12'hB00, 32'hFFFF_FFFF);
    rd_addr = 12'hB00; #1;
    chk("mcycle_bypass", {32'h0, rval32}, 64'hFFFF_FFFF);
    nxt = {exp_cyc[63:32], 32'hFFFF_FFFF};
    step(); exp_cyc = nxt;
    wr(12'hB80, 32'h0);
    rd_addr = 12'hB80; #1;
    chk("mcycleh_bypass", {32'h0, rval32}, 64'h0);
    nxt = {32'h0, exp_cyc[31:0]};
    step(); exp_cyc = nxt;
    we = 1'b0;
    chk("rv64_b80_wr_ill", {63'h0, wr_ill64}, 64'h1);
    chk("rv32_b80_wr_ok", {63'h0, wr_ill32}, 64'h0);
    rd32("mcycle_lo_held", 12'hB00, 32'hFFFF_FFFF);
    rd32("mcycleh_written", 12'hB80, 32'h0);
    step();
    rd32("mcycleh_carry", 12'hB80, exp_cyc[63:32]);
    rd32("mcycle_lo_wrap", 12'hB00, exp_cyc[31:0]);
    rd32("cycleh_alias", 12'hC80, 32'h1);

    // Full 64-bit wrap
    wr(12'hB80, 32'hFFFF_FFFF);
    nxt = {32'hFFFF_FFFF, exp_cyc[31:0]};
    step(); exp_cyc = nxt;
    wr(12'hB00, 32'hFFFF_FFFF);
    nxt = {exp_cyc[63:32], 32'hFFFF_FFFF};
    step(); exp_cyc = nxt;
    we = 1'b0;
    rd32("full_lo", 12'hB00, 32'hFFFF_FFFF);
    rd32("full_hi", 12'hB80, 32'hFFFF_FFFF);
    step();
    rd32("wrap_lo", 12'hB00, 32'h0);
    rd32("wrap_hi", 12'hB80, 32'h0);

    // Instret: retire increments, write beats retire, high-half write holds low
    retire = 1'b1;
    for (int i = 0; i < 3; i++) step();
    retire = 1'b0;
    rd32("instret_3", 12'hB02, 32'd3);
    rd32("instret_alias", 12'hC02, 32'd3);
    retire = 1'b1;
    wr(12'hB02, 32'h0);
    rd_addr = 12'hB02; #1;
    chk("minstret_bypass", {32'h0, rval32}, 64'h0);
    step(); exp_ins = 0;
    we = 1'b0;
    rd32("minstret_wr_wins", 12'hB02, 32'h0);
    step();
    retire = 1'b0;
    rd32("minstret_retire", 12'hB02, 32'h1);
    retire = 1'b1;
    wr(12'hB82, 32'h7);
    nxt = {32'h7, exp_ins[31:0]};
    step(); exp_ins = nxt;
    we = 1'b0; retire = 1'b0;
    rd32("instreth", 12'hC82, 32'h7);
    rd32("minstret_lo_held", 12'hB02, exp_ins[31:0]);

    // RV64 full-width counter write
    we = 1'b1; waddr = 12'hB00;
    wval64 = 64'h1234_5678_9ABC_DEF0; wval = 32'h9ABC_DEF0;
    nxt = {exp_cyc[63:32], 32'h9ABC_DEF0};
    step(); exp_cyc = nxt;
    we = 1'b0;
    rd_addr = 12'hB00; #1;
    chk("rv64_mcycle_wr", rval64, 64'h1234_5678_9ABC_DEF0);
    chk("rv32_mcycle_wr", {32'h0, rval32}, {32'h0, exp_cyc[31:0]});
    step();
    chk("rv64_mcycle_inc", rval64, 64'h1234_5678_9ABC_DEF1);

    // Reset dominates a concurrent illegal write and retire
    rst = 1'b1; retire = 1'b1;
    wr(12'h7FF, 32'h1);
    step();
    rst = 1'b0; retire = 1'b0; we = 1'b0;
    exp_cyc = 0; exp_ins = 0;
    chk("rst_dom_wr_ill", {63'h0, wr_ill32}, 64'h0);
    rd32("rst_dom_mcycle", 12'hB00, 32'h0);
    rd32("rst_dom_minstret", 12'hB02, 32'h0);
    rd32("rst_dom_mscratch", 12'h340, 32'h0);
    rd32("rst_dom_mepc", 12'h341, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
